// File: rtl/id_scan_controller_pkg.sv
// id_scan_controller_pkg: shared FSM states, counter state codes and defaults for the ID scan controller
package id_scan_controller_pkg;
  localparam int NUM_POS_DEF = 9;
  typedef enum logic [3:0] {S0, S1, S2, S3, S4, S5, S6, S7, S8} cnt_state_t;
  typedef enum logic [2:0] {IDLE, SYNC, CAPTURE, OFFER, WAIT, STEP, DONE} state_t;
endpackage

// File: rtl/scan_period_timer.sv
// scan_period_timer: loadable down-counter that holds at zero and flags it
module scan_period_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;
  assign zero = (count_q == '0);
  always_comb count_d = load ? load_val : (enable && !zero) ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk)
    if (reset) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/id_scan_controller.sv
// id_scan_controller: steps an external ID counter through every position and offers each digit over a valid/ready handshake
module id_scan_controller
  import id_scan_controller_pkg::*;
#(
  parameter int NUM_POS  = NUM_POS_DEF,
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          cur_state,
  input  logic [3:0]          digit_in,
  output logic                cnt_reset,
  output logic                step_out,
  output logic [3:0]          digit_out,
  output logic                digit_valid,
  input  logic                digit_ready,
  output logic [3:0]          position,
  output logic                busy,
  output logic                done,
  output logic                error
);
  state_t     state_q, state_d;
  logic [3:0] position_q, position_d;
  logic [3:0] digit_q, digit_d;
  logic       error_q, error_d;
  logic       load_timer, timer_run, timer_zero;
  logic       last_pos;
  scan_period_timer #(.W(PERIOD_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_timer),
    .enable   (timer_run),
    .load_val (period),
    .zero     (timer_zero)
  );
  assign last_pos  = (position_q == 4'(NUM_POS - 1));
  assign timer_run = (state_q == WAIT) && !pause;
  // reset is forwarded so the counter realigns to s0 together with this controller
  assign cnt_reset   = reset | (state_q == SYNC);
  assign step_out    = (state_q == STEP);
  assign digit_valid = (state_q == OFFER);
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign digit_out   = digit_q;
  assign position    = position_q;
  assign error       = error_q;
  always_comb begin
    state_d    = state_q;
    position_d = position_q;
    digit_d    = digit_q;
    error_d    = error_q;
    load_timer = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d    = SYNC;
        position_d = S0;
        error_d    = 1'b0;
      end
      SYNC: state_d = CAPTURE;
      CAPTURE: if (cur_state == position_q) begin
        digit_d = digit_in;
        state_d = OFFER;
      end else begin
        error_d = 1'b1;
        state_d = DONE;
      end
      OFFER: if (digit_ready) begin
        state_d    = last_pos ? DONE : WAIT;
        load_timer = !last_pos;
      end
      WAIT: state_d = timer_zero ? STEP : WAIT;
      STEP: begin
        position_d = position_q + 4'd1;
        state_d    = CAPTURE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q    <= IDLE;
      position_q <= '0;
      digit_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      position_q <= position_d;
      digit_q    <= digit_d;
      error_q    <= error_d;
    end
endmodule
